// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam logic REQ_0  = 1'b0;
  localparam logic REQ_1  = 1'b1;
  localparam logic ENABLE = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: on a tie the requester not granted last wins.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       valid_o
);

  always_comb begin
    grant_o = REQ_0;
    valid_o = |req_i;
    case (req_i)
      2'b01:   grant_o = REQ_0;
      2'b10:   grant_o = REQ_1;
      2'b11:   grant_o = ~last_grant_i;
      default: grant_o = REQ_0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer owning the single-port data memory controls.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_read,
  input  logic              req1_read,
  input  logic              req0_write,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req0_rdata,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              busy,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic [ADDR_W-1:0] mem_address_out,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e            state_q;
  op_e               op_q;
  logic              id_q;
  logic              last_grant_q;
  logic [3:0]        wait_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready0_q;
  logic              ready1_q;

  logic              grant_d;
  logic              grant_vld_d;
  logic              sel_write_d;
  logic              final_access;

  rr_arbiter2 u_rr (
    .req_i        ({req1_read | req1_write, req0_read | req0_write}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_d),
    .valid_o      (grant_vld_d)
  );

  // A simultaneous read+write on one requester resolves to a write.
  assign sel_write_d  = (grant_d == REQ_1) ? req1_write : req0_write;
  assign final_access = (state_q == ST_ACCESS) && (wait_cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_READ;
      id_q         <= REQ_0;
      last_grant_q <= REQ_1;
      wait_cnt_q   <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ready0_q     <= 1'b0;
      ready1_q     <= 1'b0;
    end else begin
      ready0_q <= 1'b0;
      ready1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld_d) begin
            id_q       <= grant_d;
            op_q       <= sel_write_d ? OP_WRITE : OP_READ;
            addr_q     <= (grant_d == REQ_1) ? req1_addr : req0_addr;
            wdata_q    <= (grant_d == REQ_1) ? req1_wdata : req0_wdata;
            wait_cnt_q <= WAIT_INIT;
            state_q    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wait_cnt_q != 4'd0) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end else begin
            if (op_q == OP_READ) rdata_q <= mem_data_in;
            last_grant_q <= id_q;
            ready0_q     <= (id_q == REQ_0);
            ready1_q     <= (id_q == REQ_1);
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign req0_ready      = ready0_q;
  assign req1_ready      = ready1_q;
  assign req0_rdata      = rdata_q;
  assign req1_rdata      = rdata_q;
  assign mem_read_out    = (state_q == ST_ACCESS) && (op_q == OP_READ);
  // Gated with rst so an edge that resets the FSM can never also commit a write.
  assign mem_write_out   = final_access && (op_q == OP_WRITE) && rst;
  assign mem_address_out = (state_q == ST_ACCESS) ? addr_q : '0;
  assign mem_data_out    = (state_q == ST_ACCESS) ? wdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int WA = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_rd, r0_wr, r1_rd, r1_wr;
  logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
  logic        rdy0, rdy1, busy;
  logic [31:0] rdata0, rdata1;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_dout, mem_din;

  logic        z_r0_rd;
  logic [31:0] z_r0_addr;
  logic        z_rdy0, z_rdy1, z_busy, z_mem_rd, z_mem_wr;
  logic [31:0] z_rdata0, z_rdata1, z_mem_addr, z_mem_dout, z_mem_din;

  logic [31:0] mem [16];
  logic        pl_en;
  logic [3:0]  pl_a;
  logic [31:0] pl_d;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  logic [31:0] ref_mem [16];
  logic [31:0] ref_rdata;
  int          ref_last;
  logic        p_act [2];
  logic        p_rd [2];
  logic        p_wr [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_data [2];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WA)) dut (
    .clk(clk), .rst(rst),
    .req0_read(r0_rd), .req1_read(r1_rd), .req0_write(r0_wr), .req1_write(r1_wr),
    .req0_addr(r0_addr), .req1_addr(r1_addr), .req0_wdata(r0_wdata), .req1_wdata(r1_wdata),
    .req0_ready(rdy0), .req1_ready(rdy1), .req0_rdata(rdata0), .req1_rdata(rdata1),
    .busy(busy), .mem_read_out(mem_rd), .mem_write_out(mem_wr),
    .mem_address_out(mem_addr), .mem_data_out(mem_dout), .mem_data_in(mem_din)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .req0_read(z_r0_rd), .req1_read(1'b0), .req0_write(1'b0), .req1_write(1'b0),
    .req0_addr(z_r0_addr), .req1_addr(32'h0), .req0_wdata(32'h0), .req1_wdata(32'h0),
    .req0_ready(z_rdy0), .req1_ready(z_rdy1), .req0_rdata(z_rdata0), .req1_rdata(z_rdata1),
    .busy(z_busy), .mem_read_out(z_mem_rd), .mem_write_out(z_mem_wr),
    .mem_address_out(z_mem_addr), .mem_data_out(z_mem_dout), .mem_data_in(z_mem_din)
  );

  assign mem_din   = mem_rd ? mem[mem_addr[3:0]] : 32'h0;
  assign z_mem_din = z_mem_rd ? (z_mem_addr ^ 32'h5A5A0000) : 32'h0;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[3:0]] <= mem_dout;
    else if (pl_en) mem[pl_a] <= pl_d;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive();
    r0_rd = p_act[0] & p_rd[0];
    r0_wr = p_act[0] & p_wr[0];
    r1_rd = p_act[1] & p_rd[1];
    r1_wr = p_act[1] & p_wr[1];
    r0_addr = p_addr[0]; r0_wdata = p_data[0];
    r1_addr = p_addr[1]; r1_wdata = p_data[1];
  endtask

  task automatic new_req(input int i, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    p_act[i] = 1'b1; p_rd[i] = rd; p_wr[i] = wr; p_addr[i] = a; p_data[i] = d;
  endtask

  task automatic model_reset();
    ref_last = 1;
    ref_rdata = 32'h0;
    p_act[0] = 1'b0; p_act[1] = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rdy"}, {rdy1, rdy0}, 2'b00);
    chk({tag, "_memctl"}, {mem_rd, mem_wr}, 2'b00);
    chk({tag, "_memaddr"}, mem_addr, 32'h0);
    chk({tag, "_memdata"}, mem_dout, 32'h0);
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk_quiet("idle");
  endtask

  // Called in an IDLE cycle with requests already driven; ends in the RESP cycle.
  task automatic run_txn();
    int w;
    logic is_wr;
    logic [3:0] a;
    logic [31:0] d;
    if (p_act[0] && p_act[1]) w = (ref_last == 1) ? 0 : 1;
    else w = p_act[1] ? 1 : 0;
    is_wr = p_wr[w];
    a = p_addr[w][3:0];
    d = p_data[w];
    for (int c = 1; c <= WA + 1; c++) begin
      @(negedge clk);
      chk("acc_busy", busy, 1'b1);
      chk("acc_rd", mem_rd, !is_wr);
      chk("acc_wr", mem_wr, is_wr && (c == WA + 1));
      chk("acc_addr", mem_addr, {28'h0, a});
      if (is_wr) chk("acc_wdata", mem_dout, d);
      chk("acc_rdy", {rdy1, rdy0}, 2'b00);
      if (w == 0) begin r0_addr = $urandom; r0_wdata = $urandom; end
      else begin r1_addr = $urandom; r1_wdata = $urandom; end
    end
    @(negedge clk);
    chk("resp_rdy", {rdy1, rdy0}, (w == 1) ? 2'b10 : 2'b01);
    chk("resp_memctl", {mem_rd, mem_wr}, 2'b00);
    if (is_wr) ref_mem[a] = d;
    else ref_rdata = ref_mem[a];
    ref_last = w;
    chk("rdata0", rdata0, ref_rdata);
    chk("rdata1", rdata1, ref_rdata);
    chk("mem_content", mem[a], ref_mem[a]);
    p_act[w] = 1'b0;
    drive();
  endtask

  task automatic rand_req(input int i);
    int op;
    op = $urandom_range(0, 3);
    new_req(i, op != 2, op >= 2, 32'($urandom_range(0, 15)), $urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    z_r0_rd = 1'b0; z_r0_addr = 32'h0;
    pl_en = 1'b0; pl_a = 4'h0; pl_d = 32'h0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      p_rd[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = 32'h0; p_data[i] = 32'h0;
    end
    drive();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_a = 4'(i);
      pl_d = (i == 5) ? 32'hDEADBEEF : $urandom;
      ref_mem[i] = pl_d;
    end
    @(negedge clk);
    pl_en = 1'b0;
    chk_quiet("reset");
    chk("reset_rdata", rdata0, 32'h0);
    chk("reset_z", {z_busy, z_rdy0, z_rdy1, z_mem_rd, z_mem_wr}, 5'b0);
    chk("reset_z_addr", z_mem_addr, 32'h0);

    // R0 read of preloaded word, then R1 write and R0 readback
    rst = 1'b1;
    new_req(0, 1'b1, 1'b0, 32'd5, 32'h0);
    drive();
    run_txn();
    idle_chk();
    new_req(1, 1'b0, 1'b1, 32'd7, 32'h00001234);
    drive();
    run_txn();
    idle_chk();
    new_req(0, 1'b1, 1'b0, 32'd7, 32'h0);
    drive();
    run_txn();
    chk("r0_readback", rdata0, 32'h00001234);
    idle_chk();

    // Contention from reset: both requesters keep reading
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    new_req(0, 1'b1, 1'b0, 32'd1, 32'h0);
    new_req(1, 1'b1, 1'b0, 32'd2, 32'h0);
    drive();
    for (int k = 0; k < 4; k++) begin
      run_txn();
      chk("contend_order", ref_last, k % 2);
      for (int i = 0; i < 2; i++)
        if (!p_act[i]) new_req(i, 1'b1, 1'b0, 32'(i + 1), 32'h0);
      if (k == 3) begin p_act[0] = 1'b0; p_act[1] = 1'b0; end
      drive();
      idle_chk();
    end

    // Read+write on one requester resolves to a write
    new_req(0, 1'b1, 1'b1, 32'd9, 32'hA5A5A5A5);
    drive();
    run_txn();
    chk("rw_mem9", mem[9], 32'hA5A5A5A5);
    idle_chk();

    // Reset in cycle 2 of an R1 write
    new_req(1, 1'b0, 1'b1, 32'd7, 32'hCAFE0000);
    drive();
    @(negedge clk);
    chk("rstmid_c1_busy", busy, 1'b1);
    @(negedge clk);
    chk("rstmid_c2_wr", mem_wr, 1'b0);
    rst = 1'b0;
    model_reset();
    drive();
    @(negedge clk);
    chk_quiet("rstmid_c3");
    @(negedge clk);
    chk_quiet("rstmid_c4");
    chk("rstmid_mem7", mem[7], ref_mem[7]);
    chk("rstmid_rdata", rdata1, 32'h0);
    rst = 1'b1;
    new_req(1, 1'b1, 1'b0, 32'd7, 32'h0);
    drive();
    run_txn();
    chk("rstmid_after", rdata1, 32'h00001234);
    idle_chk();

    // Reset arriving in the final ACCESS cycle must suppress the write
    new_req(0, 1'b0, 1'b1, 32'd8, 32'h0BADF00D);
    drive();
    repeat (WA + 1) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstfinal_wrgate", mem_wr, 1'b0);
    model_reset();
    drive();
    @(negedge clk);
    chk_quiet("rstfinal_after");
    chk("rstfinal_mem8", mem[8], ref_mem[8]);
    rst = 1'b1;

    // WAIT_CYCLES=0 instance: one ACCESS cycle, ready in cycle 2
    z_r0_rd = 1'b1; z_r0_addr = 32'd3;
    @(negedge clk);
    chk("z_c1_rd", {z_busy, z_mem_rd, z_rdy0}, 3'b110);
    chk("z_c1_addr", z_mem_addr, 32'd3);
    @(negedge clk);
    chk("z_c2_rdy", {z_mem_rd, z_rdy0, z_rdy1}, 3'b010);
    chk("z_c2_rdata", z_rdata0, 32'h5A5A0003);
    z_r0_rd = 1'b0;
    @(negedge clk);
    chk("z_c3_busy", {z_busy, z_rdy0}, 2'b00);

    // Randomized traffic
    rand_req($urandom_range(0, 1));
    drive();
    for (int t = 0; t < 60; t++) begin
      run_txn();
      for (int i = 0; i < 2; i++)
        if (!p_act[i] && ($urandom_range(0, 1) == 1)) rand_req(i);
      if (!p_act[0] && !p_act[1]) rand_req($urandom_range(0, 1));
      drive();
      idle_chk();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and access sequencer in front of the single-port data memory. It accepts read/write requests from two masters, instruction-side and data-side, and grants them round-robin. It drives the memory's read-enable, write-enable, address and write data for a parameterised number of wait cycles, then returns read data with a one-cycle ready pulse. It sits between the pipeline's memory-stage/fetch requesters and the data memory, and is the single owner of the memory's control inputs.

## Interface
Parameters:
- `ADDR_W`, 32: address width; word address, passed straight to memory.
- `DATA_W`, 32: data width.
- `WAIT_CYCLES`, 2: extra ACCESS cycles beyond the first; legal range 0–15.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req0_read`, `req1_read`  in  1  read request, held until ready.
- `req0_write`, `req1_write`  in  1  write request, held until ready.
- `req0_addr`, `req1_addr`  in  ADDR_W  request address.
- `req0_wdata`, `req1_wdata`  in  DATA_W  write data.
- `req0_ready`, `req1_ready`  out  1  one-cycle completion pulse.
- `req0_rdata`, `req1_rdata`  out  DATA_W  read data; valid while the matching ready is high.
- `busy`  out  1  high in any state other than IDLE.
- `mem_read_out`  out  1  memory read enable.
- `mem_write_out`  out  1  memory write enable.
- `mem_address_out`  out  ADDR_W  memory address.
- `mem_data_out`  out  DATA_W  memory write data.
- `mem_data_in`  in  DATA_W  combinational read data from memory; zero when read enable is low.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - A requester is active if its read or write is high.
  - If one requester is active, grant it.
  - If both are active, grant the one not granted last. `last_grant` resets to 1, so requester 0 wins the first tie.
  - On grant, latch requester id, op, addr and wdata. Load `wait_cnt` with WAIT_CYCLES. Go to ACCESS.
  - If read and write are both high on the same requester, latch a write; the read is dropped.
- **ACCESS**
  - Drive `mem_address_out` and `mem_data_out` from the latched registers.
  - Hold `mem_read_out` high for the whole state if op is read.
  - Assert `mem_write_out` only in the final ACCESS cycle (`wait_cnt`==0), so exactly one memory write occurs.
  - While `wait_cnt`≠0, decrement it.
  - When `wait_cnt`==0, capture `mem_data_in` into `rdata_q` (reads only), update `last_grant`, and go to RESP.
- **RESP**
  - Assert the granted requester's ready for one cycle. Always go to IDLE.
  - Requests are not sampled in RESP. A request still high in the following IDLE cycle is a new transaction; requesters drop their request the cycle after ready.
- **Read data**
  - Both `reqN_rdata` ports are driven by the shared `rdata_q`.
  - A write leaves `rdata_q` unchanged.
- **Idle outputs:** all memory outputs are 0 in IDLE and RESP.
- **Request changes:** request inputs changing after grant are ignored; the transaction uses latched values.

## Timing
- Request first high in cycle 0, with the FSM in IDLE:
  - ACCESS occupies cycles 1 … WAIT_CYCLES+1.
  - Ready is high in cycle WAIT_CYCLES+2.
- Latency = WAIT_CYCLES+2 cycles. Back-to-back throughput is one transaction per WAIT_CYCLES+3 cycles.
- Memory write edge: the rising edge ending cycle WAIT_CYCLES+1.
- Reset values: state IDLE; `wait_cnt` 0; `rdata_q` 0; `last_grant` 1; all readies, `busy` and all mem_* outputs 0.
- Reset mid-transaction:
  - `mem_write_out` is gated with `rst`, so no memory write occurs at any edge where `rst` is sampled low.
  - The transaction is abandoned with no ready pulse. The next cycle is IDLE.
- Ready outputs are registered/state-decoded only, with no combinational path from request inputs. The mem_* outputs are state- and register-decoded.

## Structure
- Shared package/include holds:
  - FSM state encoding (`ST_IDLE`, `ST_ACCESS`, `ST_RESP`, 2 bits).
  - Requester id constants (`REQ_0`, `REQ_1`).
  - The existing `ENABLE` constant.
- Natural sub-module: `rr_arbiter2`. It takes two request bits and `last_grant`, and outputs a grant index and a valid flag; it is combinational.
- Top level holds the FSM, `wait_cnt`, latched request registers and `rdata_q`.

## Test plan
- **R0 read, default WAIT_CYCLES=2:** preload mem[5]=0xDEADBEEF; assert `req0_read` with addr 5 in cycle 0. Expect `mem_read_out` high in cycles 1–3, `req0_ready` high in cycle 4 only, and `req0_rdata`=0xDEADBEEF.
- **R1 write:** addr 7, data 0x00001234. Expect `mem_write_out` high in cycle 3 only and `req1_ready` in cycle 4. A following R0 read of addr 7 returns 0x00001234.
- **Continuous contention:** hold both requesters reading, from reset. Expect grants R0, R1, R0, R1, with ready pulses alternating every 5 cycles and no starvation.
- **Read+write on same requester:** R0 asserts both with addr 9, data 0xA5A5A5A5. Expect a memory write of 0xA5A5A5A5 and `rdata_q` unchanged from its previous value.
- **Reset mid-write:** drive `rst` low in cycle 2 of an R1 write with WAIT_CYCLES=2. Expect memory unchanged, no ready pulse, all outputs 0. A request after `rst` rises completes normally.
- **WAIT_CYCLES=0:** R0 read is issued in cycle 0. Expect a single ACCESS cycle (cycle 1) and ready in cycle 2.
